clk_en_ctrl: RTL
================

// Module: clk_en_ctrl
// PURPOSE
//  Clock-enable controller for the single system clock domain. Turns clk into
//  one-cycle tick enables at a programmable divide ratio N; run/stop and
//  single-step sequencing. Feeds clock-enable pins of downstream datapath
//  blocks, which gives them slower rates without deriving new clocks.
// PARAMETERS
//  DIV_W        8   width of divide ratio register
//  DEFAULT_DIV  4   divide ratio loaded at reset (0 treated as 1)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  run        in   1      level: 1 = free-run ticks, 0 = stop
//  step       in   1      single-step request (sampled only in IDLE)
//  div_in     in   DIV_W  new divide ratio N
//  div_load   in   1      load request; hold div_in/div_load stable until div_ack
//  div_ack    out  1      one-cycle pulse: div_in accepted
//  tick       out  1      registered one-cycle enable pulse, period N cycles
//  running    out  1      state != IDLE (decoded from state register)
//  tick_cnt   out  16     present only with CLK_CTRL_TICK_CNT_EN
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, div_reg=DEFAULT_DIV, tick=0, div_ack=0,
//   running=0, tick_cnt=0. rst mid-operation aborts RUN/STEP on that edge.
//  Effective ratio Ne = (div_reg==0) ? 1 : div_reg.
//  States IDLE, RUN, STEP:
//   IDLE: cnt=0, tick=0. run=1 -> RUN; else step=1 -> STEP (run has priority).
//   RUN:  each edge: if cnt==Ne-1 {tick<=1; cnt<=0} else {tick<=0; cnt<=cnt+1}.
//         run=0 -> IDLE next edge, tick<=0, cnt<=0; partial period discarded.
//   STEP: same counting; on the edge that sets tick=1 -> IDLE. Not interruptible.
//         step/run ignored until back in IDLE.
//  Latency: entry edge E0 sets cnt=0. First tick is high after edge E0+Ne,
//   then every Ne cycles. Ne=1 gives tick held high every cycle.
//  Divide load handshake: div_load is accepted only (a) in IDLE with no
//   run/step transition that edge, or (b) in RUN on the edge where tick is set
//   (period boundary). Acceptance: div_reg<=div_in; div_ack=1 the next cycle for
//   exactly one cycle. Pending in STEP until return to IDLE. New ratio applies
//   from the following period. No partial or glitched period.
//  div_load is deasserted by the requester the cycle after div_ack. It is not
//   re-accepted while div_ack=1.
//  cnt width DIV_W; never exceeds Ne-1, so no wrap hazard.
// CONFIGURATION
//  CLK_CTRL_TICK_CNT_EN defined: tick_cnt[15:0] increments on every tick pulse.
//   Wraps 16'hFFFF->0. Cleared by rst and on the edge a div_load is accepted.
//  Undefined: tick_cnt port and counter logic are absent. All other behaviour
//   is identical.
// TESTING
//  1 rst, DEFAULT_DIV=4, run=1 at E0 -> tick high after E4,E8,E12 only;
//    running=1 from E0.
//  2 IDLE: div_in=1, div_load -> div_ack 1 cycle later; then run=1 -> tick
//    high every cycle from E1.
//  3 RUN N=4, div_in=2 loaded 1 cycle after a tick -> no ack until the next
//    tick edge; following ticks spaced 2.
//  4 IDLE N=3, step pulse -> one tick after 3 edges, running high 3 cycles,
//    back to IDLE; extra step during STEP ignored.
//  5 RUN N=5, run=0 at cnt=2 then run=1 -> no tick; next tick 5 edges after
//    re-entry. div_in=0 -> behaves as N=1. rst mid-RUN -> tick=0 next edge.
//  6 CLK_CTRL_TICK_CNT_EN, N=1 for 65537 ticks -> tick_cnt wraps to 1;
//    div_load clears it.

Source files
------------

// File: rtl/clk_en_ctrl.sv
// Clock-enable controller: divides clk into one-cycle tick enables with run/stop and single-step.
// Optional tick counter output is built when CLK_CTRL_TICK_CNT_EN is defined.
module clk_en_ctrl #(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step,
   input  logic [DIV_W-1:0] div_in,
   input  logic             div_load,
   output logic             div_ack,
   output logic             tick,
   output logic             running
`ifdef CLK_CTRL_TICK_CNT_EN
   ,
   output logic [15:0]      tick_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

   state_t           state;
   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] last;
   logic             wrap;
   logic             tick_set;
   logic             load_ok;

   // A zero ratio behaves as ratio 1, so the terminal count is 0 in both cases.
   always_comb begin
      last = '0;
      if (div_reg != '0) last = div_reg - DIV_W'(1);
   end

   assign wrap     = (cnt == last);
   assign tick_set = ((state == RUN) && run && wrap) || ((state == STEP) && wrap);

   // Loads land only where no period is in flight: quiet IDLE or a RUN period boundary.
   assign load_ok = div_load && !div_ack &&
                    (((state == IDLE) && !run && !step) ||
                     ((state == RUN) && run && wrap));

   assign running = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         div_reg <= DIV_W'(DEFAULT_DIV);
         tick    <= 1'b0;
         div_ack <= 1'b0;
      end else begin
         div_ack <= load_ok;
         if (load_ok) div_reg <= div_in;

         case (state)
            IDLE: begin
               cnt  <= '0;
               tick <= 1'b0;
               if (run)       state <= RUN;
               else if (step) state <= STEP;
            end
            RUN: begin
               if (!run) begin
                  state <= IDLE;
                  cnt   <= '0;
                  tick  <= 1'b0;
               end else if (wrap) begin
                  tick <= 1'b1;
                  cnt  <= '0;
               end else begin
                  tick <= 1'b0;
                  cnt  <= cnt + DIV_W'(1);
               end
            end
            STEP: begin
               if (wrap) begin
                  tick  <= 1'b1;
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  tick <= 1'b0;
                  cnt  <= cnt + DIV_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
               tick  <= 1'b0;
            end
         endcase
      end
   end

`ifdef CLK_CTRL_TICK_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)           tick_cnt <= '0;
      else if (load_ok)  tick_cnt <= '0;
      else if (tick_set) tick_cnt <= tick_cnt + 16'd1;
   end
`endif

endmodule
